cond_unit: RTL and testbench
============================

# cond_unit

Execute-stage condition unit for the pipelined CPU, the consumer of the ALU's `{N,Z,C,V}` flag vector. It holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against the stored flags. It also gates the instruction's register-write, memory-write and PC-source controls. Flag-register updates are split into NZ and CV groups, and are suppressed on stall, bubble or failed condition.

## Interface
Parameters:
- `FLAG_RST`, default `4'b0000`: reset value of the flag register, ordered `{N,Z,C,V}`.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: synchronous, active-low reset.
- `ValidE`, input, 1: Execute holds a real instruction (0 = bubble).
- `StallE`, input, 1: Execute is held this cycle; no state update.
- `CondE`, input, 4: instruction condition field.
- `ALUFlags`, input, 4: ALU flag output `{N,Z,C,V}`.
- `FlagWriteE`, input, 2: bit1 writes N,Z; bit0 writes C,V.
- `RegWriteE`, input, 1: ungated register-file write.
- `MemWriteE`, input, 1: ungated memory write.
- `PCSrcE`, input, 1: ungated PC redirect.
- `CondExE`, output, 1: condition passed and `ValidE`.
- `RegWriteGE`, output, 1: `RegWriteE & CondExE`.
- `MemWriteGE`, output, 1: `MemWriteE & CondExE`.
- `PCSrcGE`, output, 1: `PCSrcE & CondExE`.
- `Flags`, output, 4: current flag register `{N,Z,C,V}`.
- `SquashCnt`, output, 32: present only with `COND_SQUASH_CNT_EN`.

## Operation
- The condition is evaluated combinationally from the registered `Flags`, never from `ALUFlags`. An instruction therefore sees the flags left by the previous instruction.
- Condition decode:
  - `0000` EQ: Z. `0001` NE: !Z.
  - `0010` CS: C. `0011` CC: !C.
  - `0100` MI: N. `0101` PL: !N.
  - `0110` VS: V. `0111` VC: !V.
  - `1000` HI: C&!Z. `1001` LS: !C|Z.
  - `1010` GE: N==V. `1011` LT: N!=V.
  - `1100` GT: !Z&(N==V). `1101` LE: Z|(N!=V).
  - `1110` AL: 1. `1111`: never passes (reserved).
- `CondExE = ValidE & pass(CondE, Flags)`. All three gated outputs are forced to 0 when `CondExE=0`.
- Flag write enable is `we = {2{ValidE & ~StallE & CondExE}} & FlagWriteE`.
  - `we[1]` loads N,Z from `ALUFlags[3:2]`.
  - `we[0]` loads C,V from `ALUFlags[1:0]`.
  - A group with a 0 enable holds its value.
- Multiply and divide results arrive with C=V=0 from the ALU. The decoder issues FlagWrite `2'b10` for those operations, so C and V are preserved. The unit itself does not enforce this.

## Timing
- Gated outputs and `CondExE` are combinational in the same cycle as the Execute inputs; latency is 0.
- The flag register updates on the rising edge that ends the cycle in which `we` is non-zero. It is visible to the next instruction in Execute one cycle later.
- Stall: with `StallE=1` the flags and counter hold. Gated outputs still reflect the held instruction; the hazard unit is responsible for suppressing them.
- Reset: while `reset_n=0` at an edge, `Flags <= FLAG_RST` and `SquashCnt <= 0`.
  - Combinational outputs follow the reset flags. With the default `FLAG_RST`, EQ fails and NE passes.
  - Reset has priority over any simultaneous flag write.
- A failed-condition instruction with FlagWrite set does not modify flags (S-suffix suppressed).

## Configuration
- `COND_SQUASH_CNT_EN` defined:
  - Adds the 32-bit `SquashCnt` port.
  - The counter increments on each edge where `ValidE & ~StallE & ~CondExE` holds.
  - It wraps from `32'hFFFF_FFFF` to 0 and is cleared by reset.
- `COND_SQUASH_CNT_EN` undefined: the port and the counter register are absent, and behaviour is otherwise identical.

## Structure
- Package `cond_pkg`:
  - Enum `cond_e` with the 16 codes.
  - Flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - Localparam `FW_NZ=1`, `FW_CV=0`.
- Sub-module `cond_check`: purely combinational `(cond, flags) -> pass`, reused by any later branch-prediction check.
- Top level `cond_unit`: flag register, enable logic, output gating and the optional counter.

## Test plan
- Reset, then `CondE=0000` with `ValidE=1` and `RegWriteE=1`:
  - `Flags=0000`, `CondExE=0`, `RegWriteGE=0`.
  - Switching to `CondE=0001` gives `CondExE=1`.
- AL, `FlagWriteE=11`, `ALUFlags=0110`:
  - The next cycle shows `Flags=0110`.
  - EQ passes, HI fails, CS passes.
- Split write: from `Flags=1111`, AL with `FlagWriteE=10` and `ALUFlags=0000` gives `Flags=0011`.
- Suppression cases, all from `Flags=0000`:
  - `CondE=0000` (fail), `FlagWriteE=11`, `ALUFlags=1111`: flags stay `0000`.
  - `StallE=1` with AL and `FlagWriteE=11`: flags stay `0000`.
  - `ValidE=0` with AL and `FlagWriteE=11`: flags stay `0000`.
- Signed compares:
  - `Flags=1001` (N=V): GE and GT pass, LT and LE fail.
  - `Flags=1000`: LT passes.
  - `CondE=1111` never passes.
- With `COND_SQUASH_CNT_EN` defined:
  - Five failing valid unstalled instructions give `SquashCnt=5`.
  - A failing instruction with `StallE=1` does not count.
  - A counter preset near `FFFF_FFFF` wraps to 0.
  - `reset_n=0` clears the counter.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for the execute-stage condition unit: condition codes,
// flag bit positions and FlagWrite group indices.
package cond_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;
    localparam int unsigned FW_W   = 2;
    localparam int unsigned CNT_W  = 32;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether a condition field passes
// against an NZCV flag vector. Code 1111 is reserved and never passes.
module cond_check
    import cond_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              pass
);

    logic n, z, c, v;

    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
    end

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV flag register, conditional gating of the
// write/redirect controls, and an optional squash counter (COND_SQUASH_CNT_EN).
module cond_unit
    import cond_pkg::*;
#(
    parameter logic [FLAG_W-1:0] FLAG_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ValidE,
    input  logic              StallE,
    input  logic [COND_W-1:0] CondE,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [FW_W-1:0]   FlagWriteE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              PCSrcE,
    output logic              CondExE,
    output logic              RegWriteGE,
    output logic              MemWriteGE,
    output logic              PCSrcGE,
    output logic [FLAG_W-1:0] Flags
`ifdef COND_SQUASH_CNT_EN
    ,
    output logic [CNT_W-1:0]  SquashCnt
`endif
);

    logic [FLAG_W-1:0] flags_q;
    logic              pass;
    logic              advance;
    logic [FW_W-1:0]   we;

    // Condition is judged against the stored flags, not this cycle's ALU result
    cond_check u_cond_check (
        .cond  (CondE),
        .flags (flags_q),
        .pass  (pass)
    );

    always_comb begin
        CondExE    = ValidE & pass;
        RegWriteGE = RegWriteE & CondExE;
        MemWriteGE = MemWriteE & CondExE;
        PCSrcGE    = PCSrcE & CondExE;
        advance    = ValidE & ~StallE;
        we         = {FW_W{advance & CondExE}} & FlagWriteE;
    end

    // NZ and CV groups load independently so multiply/divide can keep C,V
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= FLAG_RST;
        end else begin
            if (we[FW_NZ]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (we[FW_CV]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    assign Flags = flags_q;

`ifdef COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_cnt_q;

    // Counts real, unstalled instructions whose condition failed; wraps freely
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            squash_cnt_q <= '0;
        end else if (advance & ~CondExE) begin
            squash_cnt_q <= squash_cnt_q + CNT_W'(1);
        end
    end

    assign SquashCnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed cases plus random traffic, with a
// queue-based scoreboard fed by the driver and drained by a negedge monitor.
module tb_cond_unit;

    logic        clk;
    logic        reset_n;
    logic        ValidE;
    logic        StallE;
    logic [3:0]  CondE;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagWriteE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        PCSrcE;
    logic        CondExE;
    logic        RegWriteGE;
    logic        MemWriteGE;
    logic        PCSrcGE;
    logic [3:0]  Flags;
`ifdef COND_SQUASH_CNT_EN
    logic [31:0] SquashCnt;
`endif

    cond_unit #(.FLAG_RST(4'b0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ValidE     (ValidE),
        .StallE     (StallE),
        .CondE      (CondE),
        .ALUFlags   (ALUFlags),
        .FlagWriteE (FlagWriteE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .PCSrcE     (PCSrcE),
        .CondExE    (CondExE),
        .RegWriteGE (RegWriteGE),
        .MemWriteGE (MemWriteGE),
        .PCSrcGE    (PCSrcGE),
        .Flags      (Flags)
`ifdef COND_SQUASH_CNT_EN
        ,
        .SquashCnt  (SquashCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic        cex;
        logic        rw;
        logic        mw;
        logic        pc;
        logic [3:0]  flags;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [3:0]  m_flags  = 4'b0000;
    logic [31:0] m_cnt    = 32'd0;

    localparam logic [3:0] EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  HI = 4'd8;
    localparam logic [3:0] GE = 4'd10, LT = 4'd11, GT = 4'd12, LE = 4'd13;
    localparam logic [3:0] AL = 4'd14, NV = 4'd15;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference predicate written from the architectural meaning of each code
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, signed_lt;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        signed_lt = (n ^ v);
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !(cy && !z);
            4'd10: return !signed_lt;
            4'd11: return signed_lt;
            4'd12: return !z && !signed_lt;
            4'd13: return z || signed_lt;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one Execute cycle, predict its outputs, then advance the model state
    task automatic step(input logic rn, input logic v, input logic s, input logic [3:0] c,
                        input logic [3:0] a, input logic [1:0] fw,
                        input logic r, input logic m, input logic p);
        exp_t e;
        bit   cex;
        @(posedge clk);
        #1;
        reset_n = rn; ValidE = v; StallE = s; CondE = c; ALUFlags = a;
        FlagWriteE = fw; RegWriteE = r; MemWriteE = m; PCSrcE = p;
        cex     = v && ref_pass(c, m_flags);
        e.chk   = rn;
        e.cex   = cex;
        e.rw    = r && cex;
        e.mw    = m && cex;
        e.pc    = p && cex;
        e.flags = m_flags;
        e.cnt   = m_cnt;
        sb_q.push_back(e);
        if (!rn) begin
            m_flags = 4'b0000;
            m_cnt   = 32'd0;
        end else if (v && !s) begin
            if (cex) begin
                if (fw[1]) m_flags[3:2] = a[3:2];
                if (fw[0]) m_flags[1:0] = a[1:0];
            end else begin
                m_cnt = m_cnt + 32'd1;
            end
        end
    endtask

    task automatic op(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw);
        step(1'b1, 1'b1, 1'b0, c, a, fw, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are combinational, so compare once per cycle on negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    chk("sb_condex", 32'(CondExE), 32'(e.cex));
                    chk("sb_regwr",  32'(RegWriteGE), 32'(e.rw));
                    chk("sb_memwr",  32'(MemWriteGE), 32'(e.mw));
                    chk("sb_pcsrc",  32'(PCSrcGE), 32'(e.pc));
                    chk("sb_flags",  32'(Flags), 32'(e.flags));
`ifdef COND_SQUASH_CNT_EN
                    chk("sb_squash", SquashCnt, e.cnt);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; ValidE = 1'b0; StallE = 1'b0; CondE = 4'd0; ALUFlags = 4'd0;
        FlagWriteE = 2'd0; RegWriteE = 1'b0; MemWriteE = 1'b0; PCSrcE = 1'b0;
        step(1'b0, 1'b0, 1'b0, EQ, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, AL, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0);

        // Reset state: EQ fails, NE passes
        op(EQ, 4'd0, 2'b00); #2;
        chk("rst_flags", 32'(Flags), 32'h0);
        chk("rst_eq_cex", 32'(CondExE), 32'h0);
        chk("rst_eq_regwr", 32'(RegWriteGE), 32'h0);
        op(NE, 4'd0, 2'b00); #2;
        chk("rst_ne_cex", 32'(CondExE), 32'h1);

        // Full write then decode against the new flags
        op(AL, 4'b0110, 2'b11);
        op(EQ, 4'd0, 2'b00); #2;
        chk("wr_flags", 32'(Flags), 32'h6);
        chk("wr_eq", 32'(CondExE), 32'h1);
        op(HI, 4'd0, 2'b00); #2;
        chk("wr_hi", 32'(CondExE), 32'h0);
        op(CS, 4'd0, 2'b00); #2;
        chk("wr_cs", 32'(CondExE), 32'h1);

        // NZ-only write keeps C,V
        op(AL, 4'hF, 2'b11);
        op(AL, 4'h0, 2'b10);
        op(AL, 4'h0, 2'b00); #2;
        chk("split_flags", 32'(Flags), 32'h3);

        // Suppression: failed condition, stall, bubble
        op(AL, 4'h0, 2'b11);
        op(EQ, 4'hF, 2'b11);
        op(AL, 4'h0, 2'b00); #2;
        chk("sup_fail", 32'(Flags), 32'h0);
        step(1'b1, 1'b1, 1'b1, AL, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1);
        op(AL, 4'h0, 2'b00); #2;
        chk("sup_stall", 32'(Flags), 32'h0);
        step(1'b1, 1'b0, 1'b0, AL, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1);
        op(AL, 4'h0, 2'b00); #2;
        chk("sup_bubble", 32'(Flags), 32'h0);

        // Signed compares
        op(AL, 4'b1001, 2'b11);
        op(GE, 4'd0, 2'b00); #2; chk("sgn_ge", 32'(CondExE), 32'h1);
        op(GT, 4'd0, 2'b00); #2; chk("sgn_gt", 32'(CondExE), 32'h1);
        op(LT, 4'd0, 2'b00); #2; chk("sgn_lt", 32'(CondExE), 32'h0);
        op(LE, 4'd0, 2'b00); #2; chk("sgn_le", 32'(CondExE), 32'h0);
        op(AL, 4'b1000, 2'b11);
        op(LT, 4'd0, 2'b00); #2; chk("sgn_lt_nv", 32'(CondExE), 32'h1);
        op(NV, 4'd0, 2'b00); #2; chk("never", 32'(CondExE), 32'h0);

`ifdef COND_SQUASH_CNT_EN
        step(1'b0, 1'b0, 1'b0, EQ, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) op(NV, 4'd0, 2'b00);
        step(1'b1, 1'b1, 1'b1, NV, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0); #2;
        chk("cnt_five", SquashCnt, 32'd5);
        op(AL, 4'd0, 2'b00); #2;
        chk("cnt_stall", SquashCnt, 32'd5);
        dut.squash_cnt_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        sb_q[sb_q.size()-1].cnt = 32'hFFFF_FFFE;
        op(NV, 4'd0, 2'b00);
        op(NV, 4'd0, 2'b00);
        op(AL, 4'd0, 2'b00); #2;
        chk("cnt_wrap", SquashCnt, 32'd0);
        op(NV, 4'd0, 2'b00);
        step(1'b0, 1'b1, 1'b0, NV, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        op(AL, 4'd0, 2'b00); #2;
        chk("cnt_reset", SquashCnt, 32'd0);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) == 0), 4'($urandom), 4'($urandom),
                 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        op(AL, 4'd0, 2'b00);
        @(posedge clk);
        @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
